// File: rtl/axi_reg_worker_pkg.sv
// Shared types, constants and helpers for the AXI5-Lite register worker.
package axi_reg_worker_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;
  localparam int ADDR_LSB   = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [AXI_DATA_W-1:0] merge_strb(
    input logic [AXI_DATA_W-1:0] old_val,
    input logic [AXI_DATA_W-1:0] new_val,
    input logic [3:0]            strb
  );
    logic [AXI_DATA_W-1:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Misaligned or wider-than-32-bit accesses are rejected.
  function automatic logic access_err(input logic [1:0] addr_lo, input logic [2:0] size);
    return (addr_lo != 2'b00) || (size > 3'b010);
  endfunction

endpackage

// File: rtl/axi_reg_worker_if.sv
// AXI5-Lite bus bundle with clock/reset carried alongside the channels.
interface AXI5_Lite_IF
  import axi_reg_worker_pkg::*;
(
  input logic ACLK,
  input logic ARESETn
);

  logic                  AWVALID;
  logic                  AWREADY;
  logic [AXI_ADDR_W-1:0] AWADDR;
  logic [2:0]            AWSIZE;
  logic [AXI_ID_W-1:0]   AWID;

  logic                  WVALID;
  logic                  WREADY;
  logic [AXI_DATA_W-1:0] WDATA;
  logic [3:0]            WSTRB;

  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic [AXI_ID_W-1:0]   BID;

  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_ADDR_W-1:0] ARADDR;
  logic [2:0]            ARSIZE;
  logic [AXI_ID_W-1:0]   ARID;

  logic                  RVALID;
  logic                  RREADY;
  logic [AXI_DATA_W-1:0] RDATA;
  logic [1:0]            RRESP;
  logic [AXI_ID_W-1:0]   RID;

  modport WORKER (
    input  ACLK, ARESETn,
    input  AWVALID, AWADDR, AWSIZE, AWID, output AWREADY,
    input  WVALID, WDATA, WSTRB,         output WREADY,
    output BVALID, BRESP, BID,           input  BREADY,
    input  ARVALID, ARADDR, ARSIZE, ARID, output ARREADY,
    output RVALID, RDATA, RRESP, RID,    input  RREADY
  );

  modport MANAGER (
    input  ACLK, ARESETn,
    output AWVALID, AWADDR, AWSIZE, AWID, input  AWREADY,
    output WVALID, WDATA, WSTRB,         input  WREADY,
    input  BVALID, BRESP, BID,           output BREADY,
    output ARVALID, ARADDR, ARSIZE, ARID, input  ARREADY,
    input  RVALID, RDATA, RRESP, RID,    output RREADY
  );

endinterface

// File: rtl/axi_reg_worker.sv
// AXI5-Lite register file worker: NUM_REGS x 32-bit registers with
// independent single-outstanding write and read paths.
module axi_reg_worker
  import axi_reg_worker_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  AXI5_Lite_IF.WORKER                 S_IF,
  output logic [NUM_REGS-1:0][31:0]   reg_o,
  output logic [NUM_REGS-1:0]         reg_wr_stb
);

  localparam int IDXW = $clog2(NUM_REGS);

  // register array
  logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]       wr_stb_q, wr_stb_d;

  // write path state
  w_state_e              w_state_q, w_state_d;
  logic [IDXW-1:0]       aw_idx_q, aw_idx_d;
  logic                  aw_err_q, aw_err_d;
  logic [AXI_ID_W-1:0]   aw_id_q, aw_id_d;
  logic [31:0]           w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [AXI_ID_W-1:0]   bid_q, bid_d;
  logic                  commit;

  // read path state
  r_state_e              r_state_q, r_state_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [AXI_ID_W-1:0]   rid_q, rid_d;

  // decoded channel fields
  logic                  aw_ready, w_ready, ar_ready;
  logic                  aw_hs, w_hs, ar_hs;
  logic [IDXW-1:0]       aw_in_idx, ar_in_idx, eff_idx;
  logic                  aw_in_err, ar_in_err, eff_err;
  logic [AXI_ID_W-1:0]   eff_id;
  logic [31:0]           eff_data;
  logic [3:0]            eff_strb;

  // READY/VALID come straight from state, never from bus inputs
  assign aw_ready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_W);
  assign w_ready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW);
  assign ar_ready = (r_state_q == R_IDLE);

  assign aw_hs = S_IF.AWVALID && aw_ready;
  assign w_hs  = S_IF.WVALID  && w_ready;
  assign ar_hs = S_IF.ARVALID && ar_ready;

  assign aw_in_idx = S_IF.AWADDR[ADDR_LSB+IDXW-1:ADDR_LSB];
  assign ar_in_idx = S_IF.ARADDR[ADDR_LSB+IDXW-1:ADDR_LSB];
  assign aw_in_err = access_err(S_IF.AWADDR[1:0], S_IF.AWSIZE);
  assign ar_in_err = access_err(S_IF.ARADDR[1:0], S_IF.ARSIZE);

  // at commit, take each field from the live channel if it handshakes now
  assign eff_idx  = aw_hs ? aw_in_idx   : aw_idx_q;
  assign eff_err  = aw_hs ? aw_in_err   : aw_err_q;
  assign eff_id   = aw_hs ? S_IF.AWID   : aw_id_q;
  assign eff_data = w_hs  ? S_IF.WDATA  : w_data_q;
  assign eff_strb = w_hs  ? S_IF.WSTRB  : w_strb_q;

  // write FSM next state, channel capture and register commit
  always_comb begin
    w_state_d = w_state_q;
    aw_idx_d  = aw_idx_q;
    aw_err_d  = aw_err_q;
    aw_id_d   = aw_id_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    regs_d    = regs_q;
    wr_stb_d  = '0;
    commit    = 1'b0;

    if (aw_hs) begin
      aw_idx_d = aw_in_idx;
      aw_err_d = aw_in_err;
      aw_id_d  = S_IF.AWID;
    end
    if (w_hs) begin
      w_data_d = S_IF.WDATA;
      w_strb_d = S_IF.WSTRB;
    end

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_IF.BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    if (commit) begin
      bid_d   = eff_id;
      bresp_d = eff_err ? RESP_SLVERR : RESP_OKAY;
      if (!eff_err) begin
        regs_d[eff_idx]   = merge_strb(regs_q[eff_idx], eff_data, eff_strb);
        wr_stb_d[eff_idx] = 1'b1;
      end
    end
  end

  // read FSM next state; data sampled from pre-write register contents
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_RESP;
          rid_d     = S_IF.ARID;
          rresp_d   = ar_in_err ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = ar_in_err ? 32'h0 : regs_q[ar_in_idx];
        end
      end
      R_RESP: begin
        if (S_IF.RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // state registers for both paths and the register array
  always_ff @(posedge S_IF.ACLK or negedge S_IF.ARESETn) begin
    if (!S_IF.ARESETn) begin
      w_state_q <= W_IDLE;
      aw_idx_q  <= '0;
      aw_err_q  <= 1'b0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      regs_q    <= {NUM_REGS{RESET_VAL}};
      wr_stb_q  <= '0;
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_idx_q  <= aw_idx_d;
      aw_err_q  <= aw_err_d;
      aw_id_q   <= aw_id_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  assign S_IF.AWREADY = aw_ready;
  assign S_IF.WREADY  = w_ready;
  assign S_IF.BVALID  = (w_state_q == W_RESP);
  assign S_IF.BRESP   = bresp_q;
  assign S_IF.BID     = bid_q;
  assign S_IF.ARREADY = ar_ready;
  assign S_IF.RVALID  = (r_state_q == R_RESP);
  assign S_IF.RDATA   = rdata_q;
  assign S_IF.RRESP   = rresp_q;
  assign S_IF.RID     = rid_q;

  assign reg_o      = regs_q;
  assign reg_wr_stb = wr_stb_q;

endmodule

// File: tb/tb_axi_reg_worker.sv
// Directed testbench for axi_reg_worker: a table of single-beat writes with
// read-back, then hand-written multi-cycle corner sequences.
module tb_axi_reg_worker;
  import axi_reg_worker_pkg::*;

  localparam int NREGS = 16;

  logic clk;
  logic rst_n;
  logic [NREGS-1:0][31:0] reg_o;
  logic [NREGS-1:0]       reg_wr_stb;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [31:0] data;
    logic [3:0]  strb;
    int          idx;
    logic [31:0] exp_reg;
    logic [1:0]  exp_resp;
    logic        exp_stb;
  } vec_t;

  vec_t vecs[6];

  AXI5_Lite_IF bus (.ACLK(clk), .ARESETn(rst_n));

  axi_reg_worker #(.NUM_REGS(NREGS), .RESET_VAL(32'h0)) dut (
    .S_IF       (bus),
    .reg_o      (reg_o),
    .reg_wr_stb (reg_wr_stb)
  );

  // 100 MHz free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare one observed value with its hand-derived expectation
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one write row with AW and W together, then read it back
  task automatic applyStimulus(input int r, input vec_t v);
    logic [15:0] exp_mask;
    exp_mask = v.exp_stb ? (16'h1 << v.idx) : 16'h0;

    bus.AWVALID = 1'b1; bus.AWADDR = v.addr; bus.AWSIZE = v.size; bus.AWID = v.id;
    bus.WVALID  = 1'b1; bus.WDATA  = v.data; bus.WSTRB  = v.strb;
    bus.BREADY  = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    checkOutput($sformatf("row%0d bvalid", r), {31'h0, bus.BVALID}, 32'h1);
    checkOutput($sformatf("row%0d bid", r), {28'h0, bus.BID}, {28'h0, v.id});
    checkOutput($sformatf("row%0d bresp", r), {30'h0, bus.BRESP}, {30'h0, v.exp_resp});
    checkOutput($sformatf("row%0d stb", r), {16'h0, reg_wr_stb}, {16'h0, exp_mask});
    checkOutput($sformatf("row%0d reg", r), reg_o[v.idx], v.exp_reg);
    tick();
    checkOutput($sformatf("row%0d stb_once", r), {16'h0, reg_wr_stb}, 32'h0);
    checkOutput($sformatf("row%0d bvalid_drop", r), {31'h0, bus.BVALID}, 32'h0);

    bus.ARVALID = 1'b1; bus.ARADDR = v.addr; bus.ARSIZE = v.size; bus.ARID = v.id ^ 4'h8;
    bus.RREADY  = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    checkOutput($sformatf("row%0d rvalid", r), {31'h0, bus.RVALID}, 32'h1);
    checkOutput($sformatf("row%0d rid", r), {28'h0, bus.RID}, {28'h0, v.id ^ 4'h8});
    checkOutput($sformatf("row%0d rresp", r), {30'h0, bus.RRESP}, {30'h0, v.exp_resp});
    checkOutput($sformatf("row%0d rdata", r), bus.RDATA,
                (v.exp_resp == RESP_OKAY) ? v.exp_reg : 32'h0);
    tick();
    checkOutput($sformatf("row%0d rvalid_drop", r), {31'h0, bus.RVALID}, 32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{32'h0000_0008, 3'b010, 4'h3, 32'hDEADBEEF, 4'hF, 2,  32'hDEADBEEF, RESP_OKAY,   1'b1};
    vecs[1] = '{32'h0000_003C, 3'b010, 4'h1, 32'h12345678, 4'h3, 15, 32'h00005678, RESP_OKAY,   1'b1};
    vecs[2] = '{32'h0000_043C, 3'b010, 4'h7, 32'hAABBCCDD, 4'hC, 15, 32'hAABB5678, RESP_OKAY,   1'b1};
    vecs[3] = '{32'h0000_000C, 3'b010, 4'h2, 32'hFFFFFFFF, 4'h0, 3,  32'h00000000, RESP_OKAY,   1'b1};
    vecs[4] = '{32'h0000_0006, 3'b010, 4'h4, 32'h00000001, 4'hF, 1,  32'h00000000, RESP_SLVERR, 1'b0};
    vecs[5] = '{32'h0000_0010, 3'b011, 4'h5, 32'h12121212, 4'hF, 4,  32'h00000000, RESP_SLVERR, 1'b0};

    rst_n = 1'b0;
    bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.AWSIZE = 3'b010; bus.AWID = '0;
    bus.WVALID  = 1'b0; bus.WDATA  = '0; bus.WSTRB  = '0;
    bus.BREADY  = 1'b0;
    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARSIZE = 3'b010; bus.ARID = '0;
    bus.RREADY  = 1'b0;

    // reset state
    tick();
    tick();
    checkOutput("rst awready", {31'h0, bus.AWREADY}, 32'h1);
    checkOutput("rst wready",  {31'h0, bus.WREADY},  32'h1);
    checkOutput("rst arready", {31'h0, bus.ARREADY}, 32'h1);
    checkOutput("rst bvalid",  {31'h0, bus.BVALID},  32'h0);
    checkOutput("rst rvalid",  {31'h0, bus.RVALID},  32'h0);
    checkOutput("rst rdata",   bus.RDATA, 32'h0);
    checkOutput("rst reg0",    reg_o[0], 32'h0);
    checkOutput("rst stb",     {16'h0, reg_wr_stb}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int r = 0; r < 6; r++) applyStimulus(r, vecs[r]);

    // W leads AW by three cycles; only lanes 0 and 2 of reg1 change
    bus.BREADY = 1'b1;
    bus.WVALID = 1'b1; bus.WDATA = 32'h11223344; bus.WSTRB = 4'h5;
    tick();
    bus.WVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("wlead wready c%0d", c), {31'h0, bus.WREADY}, 32'h0);
      checkOutput($sformatf("wlead awready c%0d", c), {31'h0, bus.AWREADY}, 32'h1);
      if (c < 2) tick();
    end
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h4; bus.AWSIZE = 3'b010; bus.AWID = 4'h6;
    tick();
    bus.AWVALID = 1'b0;
    checkOutput("wlead reg1",   reg_o[1], 32'h00220044);
    checkOutput("wlead bvalid", {31'h0, bus.BVALID}, 32'h1);
    checkOutput("wlead bid",    {28'h0, bus.BID}, 32'h6);
    checkOutput("wlead stb",    {16'h0, reg_wr_stb}, 32'h0000_0002);
    tick();

    // read with RREADY held low: response must stay put and block new AR
    bus.RREADY = 1'b0;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h8; bus.ARSIZE = 3'b010; bus.ARID = 4'h5;
    tick();
    bus.ARVALID = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("rhold rvalid c%0d", c), {31'h0, bus.RVALID}, 32'h1);
      checkOutput($sformatf("rhold rdata c%0d", c), bus.RDATA, 32'hDEADBEEF);
      checkOutput($sformatf("rhold rid c%0d", c), {28'h0, bus.RID}, 32'h5);
      checkOutput($sformatf("rhold rresp c%0d", c), {30'h0, bus.RRESP}, 32'h0);
      checkOutput($sformatf("rhold arready c%0d", c), {31'h0, bus.ARREADY}, 32'h0);
      if (c < 3) tick();
    end
    bus.RREADY = 1'b1;
    tick();
    checkOutput("rhold rvalid_drop", {31'h0, bus.RVALID}, 32'h0);
    checkOutput("rhold arready_back", {31'h0, bus.ARREADY}, 32'h1);

    // AR accepted on the same edge as a commit to the same register
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h8; bus.AWSIZE = 3'b010; bus.AWID = 4'h1;
    tick();
    bus.AWVALID = 1'b0;
    bus.WVALID  = 1'b1; bus.WDATA = 32'h5; bus.WSTRB = 4'hF;
    bus.ARVALID = 1'b1; bus.ARADDR = 32'h8; bus.ARSIZE = 3'b010; bus.ARID = 4'h9;
    tick();
    bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    checkOutput("race rdata_old", bus.RDATA, 32'hDEADBEEF);
    checkOutput("race reg2_new",  reg_o[2], 32'h5);
    tick();
    bus.ARVALID = 1'b1; bus.ARID = 4'hA;
    tick();
    bus.ARVALID = 1'b0;
    checkOutput("race rdata_new", bus.RDATA, 32'h5);
    tick();

    // reset with AW captured and W still pending
    bus.AWVALID = 1'b1; bus.AWADDR = 32'h14; bus.AWSIZE = 3'b010; bus.AWID = 4'h2;
    tick();
    bus.AWVALID = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst reg2",   reg_o[2], 32'h0);
    checkOutput("arst reg15",  reg_o[15], 32'h0);
    checkOutput("arst bvalid", {31'h0, bus.BVALID}, 32'h0);
    checkOutput("arst wready", {31'h0, bus.WREADY}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.WVALID = 1'b1; bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF;
    tick();
    bus.WVALID = 1'b0;
    checkOutput("arst lone_w stb",    {16'h0, reg_wr_stb}, 32'h0);
    checkOutput("arst lone_w bvalid", {31'h0, bus.BVALID}, 32'h0);
    tick();
    checkOutput("arst reg5",     reg_o[5], 32'h0);
    checkOutput("arst all_zero", {31'h0, |reg_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
